// File: rtl/cache_types_pkg.sv
// Shared types and width helpers for the set-associative cache controller.
package cache_types_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TAG_COMP,
        WRITEBACK,
        ALLOCATE
    } cache_state_e;

    // Index width for an n-entry table; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU for one set: victim lookup and post-access tree update.
// Nodes are heap-ordered: node n has children 2n+1 (lower half) and 2n+2 (upper half).
module plru_tree
    import cache_types_pkg::*;
#(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]          tree,
    input  logic [idx_w(WAYS)-1:0]   access_way,
    output logic [idx_w(WAYS)-1:0]   victim,
    output logic [WAYS-2:0]          tree_next
);

    localparam int LEVELS = idx_w(WAYS);

    // NOTE: blocking assignments are correct here; this is pure combinational logic,
    // and every output gets a default before the loop so no latch is inferred.
    always_comb begin
        int node;
        victim = '0;
        node   = 0;
        for (int l = 0; l < LEVELS; l++) begin
            victim[LEVELS-1-l] = tree[node];
            node = 2 * node + 1 + int'(tree[node]);
        end
    end

    // Each node on the accessed way's path is flipped to point at the other half.
    always_comb begin
        int  node;
        logic upper;
        tree_next = tree;
        node      = 0;
        for (int l = 0; l < LEVELS; l++) begin
            upper           = access_way[LEVELS-1-l];
            tree_next[node] = ~upper;
            node = 2 * node + 1 + int'(upper);
        end
    end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// Control FSM for a write-back, write-allocate set-associative cache with
// per-set tree-PLRU replacement. Tag/data/valid/dirty arrays live in the datapath.
module assoc_cache_ctrl
    import cache_types_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [idx_w(SETS)-1:0]   set_idx,
    input  logic [WAYS-1:0]          way_hit_raw,
    input  logic [WAYS-1:0]          dirty,
    input  logic                     pmem_resp,
    output logic                     mem_resp,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [WAYS-1:0]          way_wr_en,
    output logic [WAYS-1:0]          valid_wr_en,
    output logic [WAYS-1:0]          dirty_wr_en,
    output logic                     dirty_in,
    output logic [idx_w(WAYS)-1:0]   sel_way,
    output logic                     tag_sel
);

    localparam int WW = idx_w(WAYS);

    cache_state_e    state_q, state_d;
    logic [WAYS-2:0] plru_q [SETS];
    logic [WAYS-2:0] plru_cur, plru_upd;
    logic [WW-1:0]   victim_q, victim_d;
    logic [WW-1:0]   hit_way, plru_victim;
    logic            hit, req, plru_we;

    assign req      = mem_read | mem_write;
    assign hit      = |way_hit_raw;
    assign plru_cur = plru_q[set_idx];

    // Lowest-index way wins when the datapath reports more than one match.
    always_comb begin
        hit_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (way_hit_raw[i]) hit_way = WW'(i);
        end
    end

    plru_tree #(.WAYS(WAYS)) u_plru (
        .tree       (plru_cur),
        .access_way (hit_way),
        .victim     (plru_victim),
        .tree_next  (plru_upd)
    );

    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        plru_we     = 1'b0;
        mem_resp    = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        way_wr_en   = '0;
        valid_wr_en = '0;
        dirty_wr_en = '0;
        dirty_in    = 1'b0;
        sel_way     = '0;
        tag_sel     = 1'b0;
        // Outputs stay quiet while reset is held, whatever state is still registered.
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (req) state_d = TAG_COMP;
                end
                TAG_COMP: begin
                    if (!req) begin
                        state_d = IDLE;
                    end else if (hit) begin
                        mem_resp = 1'b1;
                        sel_way  = hit_way;
                        plru_we  = 1'b1;
                        if (mem_write) begin
                            way_wr_en   = WAYS'(1) << hit_way;
                            dirty_wr_en = WAYS'(1) << hit_way;
                            dirty_in    = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        victim_d = plru_victim;
                        state_d  = dirty[plru_victim] ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    pmem_write = 1'b1;
                    tag_sel    = 1'b1;
                    sel_way    = victim_q;
                    if (pmem_resp) state_d = ALLOCATE;
                end
                ALLOCATE: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        way_wr_en   = WAYS'(1) << victim_q;
                        valid_wr_en = WAYS'(1) << victim_q;
                        dirty_wr_en = WAYS'(1) << victim_q;
                        state_d     = TAG_COMP;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
            // NOTE: the PLRU array is flop-based and must come out of reset cleared,
            // so unlike a RAM it is explicitly reset here.
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (plru_we) plru_q[set_idx] <= plru_upd;
        end
    end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Randomized + directed bench for assoc_cache_ctrl (WAYS=4, SETS=8) against a
// transaction-level model with a recursive-halving PLRU.
module tb_assoc_cache_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read, mem_write;
    logic [2:0] set_idx;
    logic [3:0] way_hit_raw, dirty;
    logic       pmem_resp;
    logic       mem_resp, pmem_read, pmem_write;
    logic [3:0] way_wr_en, valid_wr_en, dirty_wr_en;
    logic       dirty_in;
    logic [1:0] sel_way;
    logic       tag_sel;

    int checks = 0;
    int errors = 0;

    bit tree [8][3];

    always #5 clk = ~clk;

    assoc_cache_ctrl #(.WAYS(4), .SETS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .set_idx     (set_idx),
        .way_hit_raw (way_hit_raw),
        .dirty       (dirty),
        .pmem_resp   (pmem_resp),
        .mem_resp    (mem_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .way_wr_en   (way_wr_en),
        .valid_wr_en (valid_wr_en),
        .dirty_wr_en (dirty_wr_en),
        .dirty_in    (dirty_in),
        .sel_way     (sel_way),
        .tag_sel     (tag_sel)
    );

    logic [18:0] obs;
    assign obs = {mem_resp, pmem_read, pmem_write, way_wr_en, valid_wr_en,
                  dirty_wr_en, dirty_in, sel_way, tag_sel};

    function automatic logic [18:0] ev(bit mr, bit pr, bit pw, logic [3:0] wwe,
                                       logic [3:0] vwe, logic [3:0] dwe, bit din,
                                       logic [1:0] sel, bit ts);
        return {mr, pr, pw, wwe, vwe, dwe, din, sel, ts};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs are applied 1 time unit after the rising edge; outputs are sampled mid-cycle.
    task automatic step(input string tag, input logic [18:0] exp);
        #3;
        check(tag, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] oh(int w);
        return 4'(1 << w);
    endfunction

    function automatic int lowest(logic [3:0] h);
        for (int i = 0; i < 4; i++) if (h[i]) return i;
        return 0;
    endfunction

    // Walk the tree by repeatedly halving the candidate way range.
    function automatic int model_victim(int s);
        int lo = 0, hi = 4, n = 0, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (tree[s][n]) begin lo = mid; n = 2 * n + 2; end
            else            begin hi = mid; n = 2 * n + 1; end
        end
        return lo;
    endfunction

    function automatic void model_touch(int s, int w);
        int lo = 0, hi = 4, n = 0, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (w >= mid) begin tree[s][n] = 1'b0; lo = mid; n = 2 * n + 2; end
            else          begin tree[s][n] = 1'b1; hi = mid; n = 2 * n + 1; end
        end
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 8; s++)
            for (int n = 0; n < 3; n++) tree[s][n] = 1'b0;
    endfunction

    task automatic idle_inputs();
        mem_read = 0; mem_write = 0; set_idx = 0; way_hit_raw = 0; dirty = 0; pmem_resp = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step("in_rst0", '0);
        step("in_rst1", '0);
        rst = 0;
        step("post_rst", '0);
        model_reset();
    endtask

    // One full CPU request. hits==0 means miss; the re-lookup then hits the filled victim.
    task automatic request(input bit rd, input bit wr, input int s, input logic [3:0] hits,
                           input logic [3:0] dty, input int wb_lat, input int fill_lat,
                           input bit drop, input bit noise);
        int v, w;
        bit last;
        mem_read = rd; mem_write = wr; set_idx = 3'(s);
        way_hit_raw = '0; dirty = dty;
        pmem_resp = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        step("idle_req", '0);
        pmem_resp = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (hits != 0) begin
            w = lowest(hits);
            way_hit_raw = hits;
            step("hit", ev(1, 0, 0, wr ? oh(w) : 4'h0, 4'h0, wr ? oh(w) : 4'h0, wr, 2'(w), 0));
            model_touch(s, w);
        end else begin
            v = model_victim(s);
            step("miss", '0);
            if (dty[v]) begin
                for (int k = 1; k <= wb_lat; k++) begin
                    pmem_resp = (k == wb_lat);
                    step("writeback", ev(0, 0, 1, 4'h0, 4'h0, 4'h0, 0, 2'(v), 1));
                end
            end
            for (int k = 1; k <= fill_lat; k++) begin
                last = (k == fill_lat);
                pmem_resp = last;
                if (drop) begin mem_read = 0; mem_write = 0; end
                step("allocate", ev(0, 1, 0, last ? oh(v) : 4'h0, last ? oh(v) : 4'h0,
                                    last ? oh(v) : 4'h0, 0, 2'b00, 0));
            end
            pmem_resp = 0;
            way_hit_raw = oh(v);
            if (drop) begin
                step("drop_tagcmp", '0);
            end else begin
                step("relookup", ev(1, 0, 0, wr ? oh(v) : 4'h0, 4'h0, wr ? oh(v) : 4'h0,
                                    wr, 2'(v), 0));
                model_touch(s, v);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        do_reset();

        // Read hit way 2 in set 3, then a miss in set 3 must evict way 0.
        request(1, 0, 3, 4'b0100, 4'h0, 1, 2, 0, 0);
        request(1, 0, 3, 4'b0000, 4'h0, 1, 2, 0, 0);

        // Write hit way 1, set 5.
        request(0, 1, 5, 4'b0010, 4'h0, 1, 1, 0, 0);

        // Clean read miss in set 0 with a five-cycle fill.
        do_reset();
        request(1, 0, 0, 4'b0000, 4'h0, 1, 5, 0, 0);

        // Dirty miss in set 2 after touching ways 0 and 1: victim way 2 gets written back.
        request(1, 0, 2, 4'b0001, 4'h0, 1, 1, 0, 0);
        request(1, 0, 2, 4'b0010, 4'h0, 1, 1, 0, 0);
        request(1, 0, 2, 4'b0000, 4'hF, 3, 2, 0, 0);

        // Multi-hit priority, read+write treated as write, dropped request, stray pmem_resp.
        request(1, 1, 4, 4'b1010, 4'h0, 1, 1, 0, 1);
        request(1, 0, 6, 4'b0000, 4'h0, 1, 3, 1, 0);
        pmem_resp = 1;
        step("idle_stray_resp", '0);
        pmem_resp = 0;
        step("idle_quiet", '0);
        request(0, 1, 6, 4'b0000, 4'hF, 2, 2, 0, 1);

        // Hits on ways 0..3 of set 7, then a miss that is reset mid-allocate.
        for (int w = 0; w < 4; w++) request(1, 0, 7, oh(w), 4'h0, 1, 1, 0, 0);
        request(1, 0, 7, 4'b0000, 4'h0, 1, 1, 0, 0);
        mem_read = 1; set_idx = 3'd7; dirty = 4'h0;
        step("idle_req_r", '0);
        step("miss_r", '0);
        step("alloc_r", ev(0, 1, 0, 4'h0, 4'h0, 4'h0, 0, 2'b00, 0));
        rst = 1;
        step("rst_mid_alloc", '0);
        rst = 0;
        mem_read = 0;
        step("after_rst_alloc", '0);
        step("idle_after_rst", '0);
        model_reset();
        request(1, 0, 7, 4'b0000, 4'h0, 1, 1, 0, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 200; n++) begin
            automatic bit wr = 1'($urandom_range(0, 1));
            automatic bit rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            automatic logic [3:0] h = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            request(rd, wr, int'($urandom_range(0, 7)), h, 4'($urandom_range(0, 15)),
                    int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                    ($urandom_range(0, 9) == 0), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
